// File: rtl/vidc_dma_scheduler.sv
// VIDC DMA scheduler: keeps the video, cursor and sound FIFOs topped up from
// system memory through one shared word-wide port, using fixed-length bursts
// from per-channel circular address pointers.
module vidc_dma_scheduler #(
  parameter int AW         = 24,
  parameter int FIFO_WORDS = 4,
  parameter int BURST      = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    vid_level,
  input  logic [3:0]    cur_level,
  input  logic [3:0]    snd_level,
  input  logic [2:0]    chan_en,
  input  logic          vsync,
  input  logic          cfg_wr,
  input  logic [2:0]    cfg_sel,
  input  logic [AW-1:0] cfg_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_chan,
  input  logic          mem_ack,
  output logic [2:0]    fifo_wr,
  output logic          busy
);

  localparam int          CW     = $clog2(BURST + 1);
  localparam logic [4:0]  BURST5 = 5'(BURST);
  localparam logic [4:0]  FIFO5  = 5'(FIFO_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST, S_SETTLE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wcnt;
  logic          vs_pend;
  logic [AW-1:0] start_q    [3];
  logic [AW-1:0] end_q      [3];
  logic [AW-1:0] ptr        [3];
  logic [2:0]    start_pend;

  logic [3:0]    lvl        [3];
  logic [2:0]    need;
  logic [1:0]    winner;
  logic          ack_evt, end_evt;
  logic [2:0]    st_wr, en_wr, chan_busy, vs_hit;
  logic [AW-1:0] start_nxt  [3];
  logic [AW-1:0] ptr_inc    [3];

  assign lvl[0] = vid_level;
  assign lvl[1] = cur_level;
  assign lvl[2] = snd_level;

  // Per-channel need, fixed-priority winner and config/pointer helpers.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    need    = '0;
    winner  = 2'd0;
    st_wr   = '0;
    en_wr   = '0;
    chan_busy = '0;
    vs_hit  = {1'b0, vsync, vsync};
    ack_evt = (state == S_BURST) && mem_ack;
    end_evt = ack_evt && (wcnt == CW'(1));
    for (int c = 0; c < 3; c++) begin
      need[c]      = chan_en[c] && (({1'b0, lvl[c]} + BURST5) <= FIFO5);
      st_wr[c]     = cfg_wr && (cfg_sel[2:1] == 2'(c)) && !cfg_sel[0];
      en_wr[c]     = cfg_wr && (cfg_sel[2:1] == 2'(c)) &&  cfg_sel[0];
      chan_busy[c] = ((state == S_GRANT) || (state == S_BURST)) && (mem_chan == 2'(c));
      start_nxt[c] = st_wr[c] ? cfg_data : start_q[c];
      ptr_inc[c]   = (ptr[c] == end_q[c]) ? start_q[c] : ptr[c] + AW'(1);
    end
    if (need[2])      winner = 2'd2;
    else if (need[1]) winner = 2'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: arbitrate in IDLE, run the burst, settle one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (|need) state_nxt = S_GRANT;
      S_GRANT:  state_nxt = S_BURST;
      S_BURST:  if (end_evt) state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs: request during BURST, steer each accepted word to its FIFO.
  always_comb begin
    mem_req  = (state == S_BURST);
    busy     = (state != S_IDLE);
    fifo_wr  = '0;
    mem_addr = '0;
    case (mem_chan)
      2'd0:    mem_addr = ptr[0];
      2'd1:    mem_addr = ptr[1];
      2'd2:    mem_addr = ptr[2];
      default: mem_addr = '0;
    endcase
    if (ack_evt) begin
      case (mem_chan)
        2'd0:    fifo_wr = 3'b001;
        2'd1:    fifo_wr = 3'b010;
        2'd2:    fifo_wr = 3'b100;
        default: fifo_wr = 3'b000;
      endcase
    end
  end

  // Burst bookkeeping, config registers and circular pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_chan   <= 2'd0;
      wcnt       <= '0;
      vs_pend    <= 1'b0;
      start_pend <= '0;
      // NOTE: these are three-entry register banks, not a RAM, so resetting them is cheap and required.
      for (int c = 0; c < 3; c++) begin
        start_q[c] <= '0;
        end_q[c]   <= '0;
        ptr[c]     <= '0;
      end
    end else begin
      if (state == S_IDLE && |need) begin
        mem_chan <= winner;
        wcnt     <= CW'(BURST);
      end else if (ack_evt) begin
        wcnt <= wcnt - CW'(1);
      end

      // A vsync that hits a busy video/cursor burst is replayed at burst end.
      if (end_evt)
        vs_pend <= 1'b0;
      else if (vsync && (chan_busy[0] || chan_busy[1]))
        vs_pend <= 1'b1;

      for (int c = 0; c < 3; c++) begin
        if (st_wr[c]) start_q[c] <= cfg_data;
        if (en_wr[c]) end_q[c]   <= cfg_data;

        if (end_evt && mem_chan == 2'(c))
          start_pend[c] <= 1'b0;
        else if (st_wr[c] && chan_busy[c])
          start_pend[c] <= 1'b1;

        // A busy channel only moves on acks; deferred reloads win over the last increment.
        if (chan_busy[c]) begin
          if (end_evt && (start_pend[c] || vs_pend || vs_hit[c] || st_wr[c]))
            ptr[c] <= start_nxt[c];
          else if (ack_evt)
            ptr[c] <= ptr_inc[c];
        end else if (vs_hit[c] || st_wr[c]) begin
          ptr[c] <= start_nxt[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_vidc_dma_scheduler.sv
// Self-checking bench for vidc_dma_scheduler: a FIFO level model reacts to
// fifo_wr, and a scoreboard of expected (channel, address) words is filled as
// stimulus is applied and drained as the memory handshake completes.
module tb_vidc_dma_scheduler;

  localparam int AW    = 24;
  localparam int BURST = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    lvl [3];
  logic [2:0]    chan_en;
  logic          vsync, cfg_wr, mem_ack;
  logic [2:0]    cfg_sel;
  logic [AW-1:0] cfg_data;
  logic          mem_req, busy;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_chan;
  logic [2:0]    fifo_wr;

  vidc_dma_scheduler #(.AW(AW), .FIFO_WORDS(4), .BURST(BURST)) dut (
    .clk(clk), .reset_n(reset_n),
    .vid_level(lvl[0]), .cur_level(lvl[1]), .snd_level(lvl[2]),
    .chan_en(chan_en), .vsync(vsync), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_chan(mem_chan), .mem_ack(mem_ack), .fifo_wr(fifo_wr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    chan;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [AW-1:0] m_start [3];
  logic [AW-1:0] m_end   [3];
  logic [AW-1:0] m_ptr   [3];
  int            pend_inc [3];
  int            stall_left = 0;
  bit            stall_seen = 0;
  logic [AW-1:0] stall_addr;
  bit            vs_arm = 0;
  logic [AW-1:0] vs_addr;
  int            req_seen = 0;
  int            first_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Queue the words of one burst for channel c and advance the model pointer.
  task automatic push_burst(input int c);
    exp_t e;
    for (int i = 0; i < BURST; i++) begin
      e.chan = 2'(c);
      e.addr = m_ptr[c];
      exp_q.push_back(e);
      m_ptr[c] = (m_ptr[c] == m_end[c]) ? m_start[c] : m_ptr[c] + AW'(1);
    end
  endtask

  // One clock: apply level updates, drive ack/vsync, then score the handshake.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      lvl[c] = lvl[c] + 4'(pend_inc[c]);
      pend_inc[c] = 0;
    end
    vsync   = 1'b0;
    cfg_wr  = 1'b0;
    mem_ack = 1'b0;
    if (mem_req === 1'b1) begin
      req_seen++;
      if (vs_arm && mem_addr == vs_addr) begin
        vsync  = 1'b1;
        vs_arm = 0;
      end else if (stall_left > 0) begin
        if (!stall_seen) begin
          stall_addr = mem_addr;
          stall_seen = 1;
        end else begin
          check("stall_addr", 32'(mem_addr), 32'(stall_addr));
        end
        check("fifo_wr_stall", 32'(fifo_wr), 32'd0);
        stall_left--;
      end else begin
        mem_ack = 1'b1;
      end
    end
    #1;
    if (mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(mem_req), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("word_chan", 32'(mem_chan), 32'(e.chan));
        check("word_addr", 32'(mem_addr), 32'(e.addr));
        check("word_fifo_wr", 32'(fifo_wr), 32'(3'b001 << e.chan));
        pend_inc[e.chan]++;
      end
    end else if (fifo_wr !== 3'b000) begin
      check("fifo_wr_idle", 32'(fifo_wr), 32'd0);
    end
  endtask

  // Run until the scoreboard drains (bounded), then idle to catch extra words.
  task automatic run(input int budget, output int first);
    int n;
    n = 0;
    first = -1;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
      if (first < 0 && mem_req === 1'b1) first = n;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (6) cycle();
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [AW-1:0] data);
    int c;
    cfg_sel  = sel;
    cfg_data = data;
    cfg_wr   = 1'b1;
    c = int'(sel[2:1]);
    if (c < 3) begin
      if (sel[0]) m_end[c] = data;
      else begin
        m_start[c] = data;
        m_ptr[c]   = data;
      end
    end
    cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    chan_en = 3'b000;
    vsync = 1'b0; cfg_wr = 1'b0; mem_ack = 1'b0;
    cfg_sel = '0; cfg_data = '0;
    for (int c = 0; c < 3; c++) begin
      lvl[c] = 4'd0; pend_inc[c] = 0;
      m_start[c] = '0; m_end[c] = '0; m_ptr[c] = '0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req",  32'(mem_req),  32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_chan", 32'(mem_chan), 32'd0);
    check("rst_fifo_wr",  32'(fifo_wr),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    #1 reset_n = 1'b1;

    // Stray ack while idle must not write a FIFO.
    @(posedge clk);
    #2 mem_ack = 1'b1;
    #1;
    check("idle_ack_fifo_wr", 32'(fifo_wr), 32'd0);
    check("idle_ack_busy",    32'(busy),    32'd0);
    mem_ack = 1'b0;

    cfg_write(3'b000, 24'h000100);
    cfg_write(3'b001, 24'h000103);
    cfg_write(3'b010, 24'h000200);
    cfg_write(3'b011, 24'h00020F);
    cfg_write(3'b100, 24'h000300);
    cfg_write(3'b101, 24'h00030F);
    cfg_write(3'b110, 24'h00ABCD);

    // Refill video from empty: two bursts, END inclusive wrap afterwards.
    lvl[0]  = 4'd0;
    chan_en = 3'b001;
    push_burst(0);
    push_burst(0);
    run(100, first_req);
    check("refill_latency", 32'(first_req), 32'd2);
    lvl[0] = 4'd0;
    push_burst(0);
    push_burst(0);
    run(100, first_req);

    // Priority: snd > cur > vid, each channel refilled until full.
    for (int c = 0; c < 3; c++) lvl[c] = 4'd0;
    chan_en = 3'b111;
    push_burst(2); push_burst(2);
    push_burst(1); push_burst(1);
    push_burst(0); push_burst(0);
    run(200, first_req);

    // Full: three words used leaves no room for a burst.
    chan_en  = 3'b001;
    lvl[0]   = 4'd3;
    req_seen = 0;
    repeat (10) cycle();
    check("full_no_req", 32'(req_seen), 32'd0);
    lvl[0] = 4'd2;
    push_burst(0);
    run(100, first_req);
    check("full_latency", 32'(first_req), 32'd2);

    // Stall: ack withheld for five request cycles.
    lvl[0]     = 4'd2;
    stall_left = 5;
    stall_seen = 0;
    push_burst(0);
    run(100, first_req);
    check("stall_cycles", 32'(stall_left), 32'd0);

    // vsync while the video burst is at 0x101: deferred reload to START.
    cfg_write(3'b000, 24'h000100);
    lvl[0]  = 4'd2;
    vs_arm  = 1;
    vs_addr = 24'h000101;
    push_burst(0);
    m_ptr[0] = m_start[0];
    m_ptr[1] = m_start[1];
    run(100, first_req);
    check("vsync_fired", 32'(vs_arm), 32'd0);
    lvl[0] = 4'd2;
    push_burst(0);
    run(100, first_req);

    // Reset in the middle of a stalled burst.
    lvl[0]     = 4'd2;
    stall_left = 1000;
    stall_seen = 0;
    for (int i = 0; i < 10 && mem_req !== 1'b1; i++) cycle();
    check("rst_pre_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    #1;
    check("rst_pre_fifo_wr", 32'(fifo_wr), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_mem_req",  32'(mem_req),  32'd0);
    check("rst_mid_fifo_wr",  32'(fifo_wr),  32'd0);
    check("rst_mid_busy",     32'(busy),     32'd0);
    check("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    mem_ack    = 1'b0;
    stall_left = 0;
    stall_seen = 0;
    for (int c = 0; c < 3; c++) begin
      m_start[c] = '0; m_end[c] = '0; m_ptr[c] = '0; pend_inc[c] = 0;
    end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    push_burst(0);
    run(100, first_req);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
